// File: rtl/m_wb_gpio_if.sv
// Wishbone classic slave bus bundle for the m_wb_gpio port.
// Signal names follow the slave-side view (core outputs arrive as *_I).
interface m_wb_gpio_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [1:0]  ADR_I;
  logic [3:0]  SEL_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/m_wb_gpio.sv
// Wishbone classic GPIO slave: NOUT outputs with set/clear aliases, NIN synced inputs.
// Optional sticky edge flags and irq when macro GPIO_EDGE_EN is defined.
module m_wb_gpio #(
  parameter int          NOUT       = 4,
  parameter int          NIN        = 1,
  parameter int          SYNCSTAGES = 2,
  parameter logic [31:0] OUTRST     = 32'h1
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  m_wb_gpio_if.slave      wb,
  output logic [NOUT-1:0] gpo,
  input  logic [NIN-1:0]  gpi,
  output logic            irq
);

  localparam logic [31:0] OMASK =
    (NOUT >= 32) ? 32'hFFFF_FFFF : ((32'h1 << NOUT) - 32'h1);

  logic [31:0]    out_q, out_d;
  logic           ack_q, ack_d;
  logic [31:0]    dat_q, dat_d;
  logic [NIN-1:0] sync_q [SYNCSTAGES];
  logic [31:0]    lane_m;
  logic [31:0]    wmask;
  logic [31:0]    in_ext;
  logic [31:0]    rdata;
  logic           req;
  logic           wr;

  assign req = wb.CYC_I & wb.STB_I & ~ack_q & ~RST_I;
  assign wr  = req & wb.WE_I;

  always_comb begin
    lane_m = '0;
    for (int b = 0; b < 32; b++) lane_m[b] = wb.SEL_I[b/8];
    wmask = wb.DAT_I & lane_m & OMASK;
  end

  always_comb begin
    in_ext = '0;
    in_ext[NIN-1:0] = sync_q[SYNCSTAGES-1];
  end

`ifdef GPIO_EDGE_EN
  logic [NIN-1:0] prev_q;
  logic [NIN-1:0] edge_q, edge_d;
  logic [NIN-1:0] edge_clr;
  logic           irq_q;
  logic [31:0]    edge_ext;

  always_comb begin
    edge_clr = '0;
    for (int i = 0; i < NIN; i++)
      edge_clr[i] = wb.DAT_I[i] & lane_m[i];
    if (!(wr && wb.ADR_I == 2'd3)) edge_clr = '0;
    // a fresh edge in the clearing cycle keeps the flag set
    edge_d = (edge_q & ~edge_clr) | (sync_q[SYNCSTAGES-1] ^ prev_q);
    edge_ext = '0;
    edge_ext[NIN-1:0] = edge_q;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      prev_q <= '0;
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= sync_q[SYNCSTAGES-1];
      edge_q <= edge_d;
      irq_q  <= |edge_q;
    end
  end

  assign irq = irq_q;
`else
  logic [31:0] edge_ext;
  assign edge_ext = out_q;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rdata = out_q;
    unique case (wb.ADR_I)
      2'd0:    rdata = out_q;
      2'd1:    rdata = in_ext;
      2'd2:    rdata = out_q;
      2'd3:    rdata = edge_ext;
      default: rdata = out_q;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (wr) begin
      unique case (wb.ADR_I)
        2'd0:    out_d = (out_q & ~(lane_m & OMASK)) | wmask;
        2'd2:    out_d = out_q | wmask;
        2'd3:    out_d = out_q & ~wmask;
        default: out_d = out_q;
      endcase
    end
  end

  assign ack_d = req;
  assign dat_d = req ? rdata : 32'h0;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      out_q <= OUTRST & OMASK;
      ack_q <= 1'b0;
      dat_q <= '0;
      for (int k = 0; k < SYNCSTAGES; k++) sync_q[k] <= '0;
    end else begin
      out_q <= out_d;
      ack_q <= ack_d;
      dat_q <= dat_d;
      sync_q[0] <= gpi;
      for (int k = 1; k < SYNCSTAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign gpo       = out_q[NOUT-1:0];
  assign wb.ACK_O  = ack_q;
  assign wb.DAT_O  = dat_q;

endmodule

// File: tb/tb_m_wb_gpio.sv
// Directed bench for m_wb_gpio (NOUT=4, NIN=1, SYNCSTAGES=2, OUTRST=1).
module tb_m_wb_gpio;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gpo;
  logic [0:0] gpi;
  logic       irq;
  int         vec = 0;
  int         bad = 0;
  logic       ack_s;
  logic [31:0] dat_s;
  logic [3:0] gpo_s;

  m_wb_gpio_if bus ();

  m_wb_gpio #(
    .NOUT(4), .NIN(1), .SYNCSTAGES(2), .OUTRST(32'h1)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .wb(bus.slave),
    .gpo(gpo),
    .gpi(gpi),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ADR_I = 2'd0;
    bus.SEL_I = 4'h0;
    bus.DAT_I = 32'h0;
  endtask

  task automatic xfer(input logic we, input logic [1:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat);
    @(negedge clk);
    bus.CYC_I = 1'b1;
    bus.STB_I = 1'b1;
    bus.WE_I  = we;
    bus.ADR_I = adr;
    bus.SEL_I = sel;
    bus.DAT_I = dat;
    @(posedge clk);
    #1;
    ack_s = bus.ACK_O;
    dat_s = bus.DAT_O;
    gpo_s = gpo;
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    gpi = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpo", {28'h0, gpo}, 32'h1);
    chk("rst_ack", {31'h0, bus.ACK_O}, 32'h0);
    chk("rst_dat", bus.DAT_O, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    xfer(1'b1, 2'd0, 4'hF, 32'hA);
    chk("wr0_ack", {31'h0, ack_s}, 32'h1);
    chk("wr0_gpo", {28'h0, gpo_s}, 32'hA);
    xfer(1'b0, 2'd0, 4'hF, 32'h0);
    chk("rd0_ack", {31'h0, ack_s}, 32'h1);
    chk("rd0_dat", dat_s, 32'hA);

    xfer(1'b1, 2'd2, 4'hF, 32'h5);
    chk("set_gpo", {28'h0, gpo_s}, 32'hF);
    xfer(1'b1, 2'd3, 4'hF, 32'h3);
    chk("clr_gpo", {28'h0, gpo_s}, 32'hC);
    xfer(1'b1, 2'd0, 4'h0, 32'hF);
    chk("sel0_ack", {31'h0, ack_s}, 32'h1);
    chk("sel0_gpo", {28'h0, gpo_s}, 32'hC);
    xfer(1'b1, 2'd0, 4'hE, 32'h0);
    chk("lane1_gpo", {28'h0, gpo_s}, 32'hC);
    xfer(1'b1, 2'd1, 4'hF, 32'h3);
    chk("wrin_ack", {31'h0, ack_s}, 32'h1);
    chk("wrin_gpo", {28'h0, gpo_s}, 32'hC);
    xfer(1'b0, 2'd2, 4'hF, 32'h0);
    chk("rd2_dat", dat_s, 32'hC);
`ifndef GPIO_EDGE_EN
    xfer(1'b0, 2'd3, 4'hF, 32'h0);
    chk("rd3_dat", dat_s, 32'hC);
`endif

    @(negedge clk);
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b1;
    bus.SEL_I = 4'hF;
    bus.DAT_I = 32'h3;
    @(posedge clk);
    #1;
    chk("nocyc_ack", {31'h0, bus.ACK_O}, 32'h0);
    chk("nocyc_gpo", {28'h0, gpo}, 32'hC);
    @(negedge clk);
    idle();

    @(negedge clk);
    gpi = 1'b1;
    bus.CYC_I = 1'b1;
    bus.STB_I = 1'b1;
    bus.ADR_I = 2'd1;
    @(posedge clk);
    #1;
    chk("sync_early", bus.DAT_O, 32'h0);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    gpi = 1'b0;
    bus.CYC_I = 1'b1;
    bus.STB_I = 1'b1;
    bus.ADR_I = 2'd1;
    @(posedge clk);
    #1;
    chk("hold_ack1", {31'h0, bus.ACK_O}, 32'h1);
    chk("hold_dat1", bus.DAT_O, 32'h1);
    @(posedge clk);
    #1;
    chk("hold_ack2", {31'h0, bus.ACK_O}, 32'h0);
    chk("hold_dat2", bus.DAT_O, 32'h0);
    @(posedge clk);
    #1;
    chk("hold_ack3", {31'h0, bus.ACK_O}, 32'h1);
    chk("hold_dat3", bus.DAT_O, 32'h0);
    @(posedge clk);
    #1;
    chk("hold_ack4", {31'h0, bus.ACK_O}, 32'h0);
    @(negedge clk);
    idle();

`ifdef GPIO_EDGE_EN
    repeat (4) @(negedge clk);
    xfer(1'b1, 2'd3, 4'hF, 32'h0);
    xfer(1'b1, 2'd3, 4'hF, 32'h1);
    repeat (2) @(negedge clk);
    chk("edge_irq_off", {31'h0, irq}, 32'h0);
    gpi = 1'b1;
    repeat (5) @(negedge clk);
    chk("edge_irq_on", {31'h0, irq}, 32'h1);
    xfer(1'b0, 2'd3, 4'hF, 32'h0);
    chk("edge_rd", dat_s, 32'h1);
    xfer(1'b1, 2'd3, 4'hF, 32'h1);
    repeat (2) @(negedge clk);
    chk("edge_w1c_irq", {31'h0, irq}, 32'h0);
`endif

    @(negedge clk);
    rst = 1'b1;
    bus.CYC_I = 1'b1;
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b1;
    bus.ADR_I = 2'd0;
    bus.SEL_I = 4'hF;
    bus.DAT_I = 32'hE;
    @(posedge clk);
    #1;
    chk("rstx_ack", {31'h0, bus.ACK_O}, 32'h0);
    chk("rstx_gpo", {28'h0, gpo}, 32'h1);
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstx_ack2", {31'h0, bus.ACK_O}, 32'h0);
    chk("rstx_gpo2", {28'h0, gpo}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
